// File: rtl/eth_vlg_tx_arb.sv
// eth_vlg_tx_arb
// Round-robin transmit arbiter that shares one byte-wide PHY stream between
// N frame generators. One source is granted at a time. Its bytes are
// forwarded with one cycle of latency. A fixed inter-frame gap follows every
// frame. A grant is revoked if the source never starts, and a frame is cut
// if it runs past MAX_LEN bytes.
//
// Ports:
//   clk          transmit clock
//   rst          asynchronous active-low reset
//   req[N]       per-source frame request (level, sampled only while idle)
//   in_d[N][8]   per-source data byte
//   in_v[N]      per-source data valid
//   grant[N]     one-hot grant
//   out_d[8]     data to PHY (holds last value while out_v is low)
//   out_v        valid to PHY
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse: grant revoked, source never raised in_v
//   err_trunc    one-cycle pulse: frame cut at MAX_LEN bytes
module eth_vlg_tx_arb #(
  parameter int N            = 4,
  parameter int IFG          = 12,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int MAX_LEN      = 1536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0][7:0]   in_d,
  input  logic [N-1:0]        in_v,
  output logic [N-1:0]        grant,
  output logic [7:0]          out_d,
  output logic                out_v,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_trunc
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam int GW = $clog2(IFG + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_XFER, ST_IFG} state_t;

  state_t           r_state, w_state_n;
  logic [PW-1:0]    r_ptr, w_ptr_n;
  logic [PW-1:0]    r_sel, w_sel_n;
  logic [WW-1:0]    r_wait, w_wait_n;
  logic [15:0]      r_cnt, w_cnt_n;
  logic [GW-1:0]    r_gap, w_gap_n;
  logic [N-1:0]     r_grant, w_grant_n;
  logic [7:0]       r_out_d, w_out_d_n;
  logic             r_out_v, w_out_v_n;
  logic             r_tout, w_tout_n;
  logic             r_trunc, w_trunc_n;

  logic             w_any;
  logic [PW-1:0]    w_win;
  logic [PW:0]      w_idx;
  logic [PW:0]      w_inc;
  logic [PW-1:0]    w_ptr_adv;
  logic             w_in_v;
  logic [7:0]       w_in_d;
  logic             w_at_max;
  logic             w_wait_done;
  logic             w_gap_done;

  assign w_in_v      = in_v[r_sel];
  assign w_in_d      = in_d[r_sel];
  assign w_at_max    = (r_cnt == 16'(MAX_LEN));
  assign w_wait_done = (r_wait == WW'(WAIT_TIMEOUT - 1));
  assign w_gap_done  = (r_gap == GW'(IFG - 1));

  // Round-robin scan: start at r_ptr and take the first requester found,
  // wrapping the index back into 0..N-1 without a modulo operator.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!w_any && req[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[PW-1:0];
      end
    end
  end

  // Pointer moves to the source just after the winner so it gets lowest
  // priority next time.
  always_comb begin
    w_inc     = {1'b0, w_win} + (PW+1)'(1);
    w_ptr_adv = (w_inc == (PW+1)'(N)) ? '0 : w_inc[PW-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_n = ST_GRANT;
      ST_GRANT: begin
        if (w_in_v)           w_state_n = ST_XFER;
        else if (w_wait_done) w_state_n = ST_IDLE;
      end
      ST_XFER: begin
        // A zero-length gap skips the IFG state entirely.
        if (!w_in_v || w_at_max) w_state_n = (IFG == 0) ? ST_IDLE : ST_IFG;
      end
      ST_IFG:   if (w_gap_done) w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
  end

  // Output and datapath next values. out_d only updates on forwarded bytes,
  // so it holds the last real byte while out_v is low.
  always_comb begin
    w_grant_n = r_grant;
    w_out_d_n = r_out_d;
    w_out_v_n = 1'b0;
    w_tout_n  = 1'b0;
    w_trunc_n = 1'b0;
    w_ptr_n   = r_ptr;
    w_sel_n   = r_sel;
    w_wait_n  = r_wait;
    w_cnt_n   = r_cnt;
    w_gap_n   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_n = N'(1) << w_win;
          w_sel_n   = w_win;
          w_ptr_n   = w_ptr_adv;
          w_wait_n  = '0;
        end
      end
      ST_GRANT: begin
        w_wait_n = r_wait + WW'(1);
        if (w_in_v) begin
          w_out_d_n = w_in_d;
          w_out_v_n = 1'b1;
          w_cnt_n   = 16'd1;
        end else if (w_wait_done) begin
          w_grant_n = '0;
          w_tout_n  = 1'b1;
        end
      end
      ST_XFER: begin
        if (!w_in_v) begin
          w_grant_n = '0;
          w_gap_n   = '0;
        end else if (w_at_max) begin
          // Byte arriving at the limit is dropped; the source sees grant
          // fall and must abandon the rest of its frame.
          w_grant_n = '0;
          w_trunc_n = 1'b1;
          w_gap_n   = '0;
        end else begin
          w_out_d_n = w_in_d;
          w_out_v_n = 1'b1;
          w_cnt_n   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        end
      end
      ST_IFG: begin
        w_gap_n = r_gap + GW'(1);
      end
      default: begin
        w_grant_n = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_sel   <= '0;
      r_wait  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_grant <= '0;
      r_out_d <= '0;
      r_out_v <= 1'b0;
      r_tout  <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_n;
      r_sel   <= w_sel_n;
      r_wait  <= w_wait_n;
      r_cnt   <= w_cnt_n;
      r_gap   <= w_gap_n;
      r_grant <= w_grant_n;
      r_out_d <= w_out_d_n;
      r_out_v <= w_out_v_n;
      r_tout  <= w_tout_n;
      r_trunc <= w_trunc_n;
    end
  end

  assign grant       = r_grant;
  assign out_d       = r_out_d;
  assign out_v       = r_out_v;
  assign busy        = (r_state != ST_IDLE);
  assign err_timeout = r_tout;
  assign err_trunc   = r_trunc;

endmodule

// File: doc/eth_vlg_tx_arb.md
# eth_vlg_tx_arb

Transmit-side arbiter sharing the single byte-wide PHY output stream (`phy.out`: `d`, `v`) between N packet generators (ARP replies, ICMP replies, DHCP client, UDP, TCP). It grants one source at a time using round-robin priority, forwards that source's frame byte-for-byte with one cycle of latency, and enforces an inter-frame gap. It guards against a granted source that never starts a frame, or one that never ends it.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `IFG`, 12, idle cycles inserted after every frame, counted on `clk`
- `WAIT_TIMEOUT`, 1024, cycles a granted source may take to raise its `v` before grant is revoked
- `MAX_LEN`, 1536, maximum bytes per frame; longer frames are truncated (≤ 65535)

Ports:
- `clk`  in  1  transmit clock
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  N  per-source frame request, level
- `in_d`  in  N×8  per-source data byte (`[N-1:0][7:0]`)
- `in_v`  in  N  per-source data valid
- `grant`  out  N  one-hot grant
- `out_d`  out  8  data to PHY
- `out_v`  out  1  valid to PHY
- `busy`  out  1  high in every state except IDLE
- `err_timeout`  out  1  one-cycle pulse: grant revoked, no `in_v` seen
- `err_trunc`  out  1  one-cycle pulse: frame cut at `MAX_LEN`

## Operation
- Reset (asynchronous assert, synchronous deassert at the source):
  - all outputs 0
  - state IDLE
  - round-robin pointer `ptr` = 0
  - counters 0
- **IDLE**
  - If `req` ≠ 0, winner `w` = first index with `req` set, scanning `ptr, ptr+1, …` modulo N.
  - Next cycle: `grant[w]`=1, `ptr` ← (w+1) mod N, wait counter cleared, go to GRANT.
  - `req` is sampled only in IDLE.
- **GRANT**
  - Wait counter increments each cycle.
  - If `in_v[w]`=1: `out_d`←`in_d[w]`, `out_v`←1, byte count ← 1, go to XFER.
  - Else, if the wait counter reaches `WAIT_TIMEOUT`-1: `grant`←0, pulse `err_timeout`, go to IDLE. No gap is inserted because nothing was sent.
- **XFER**
  - Each cycle: `out_d`←`in_d[w]`, `out_v`←`in_v[w]`.
  - First cycle with `in_v[w]`=0 ends the frame: `out_v`←0, `grant`←0, gap counter cleared, go to IFG.
  - If `in_v[w]`=1 when byte count = `MAX_LEN`: `out_v`←0, `grant`←0, pulse `err_trunc`, go to IFG. The source's remaining bytes are dropped. The source must observe `grant` low and abort.
  - Byte count is 16 bits and saturates. It never wraps.
- **IFG**
  - `out_v`=0 for exactly `IFG` cycles after the last valid byte, then go to IDLE.
  - With `IFG`=0, go directly to IDLE.
- `in_v`/`in_d` of non-granted sources are ignored in all states.
- Deasserting `req` while granted has no effect; the frame is delimited by `in_v` only.
- Sources must hold `in_v` contiguous per frame. A gap in `in_v` ends the frame.

## Timing
- Grant latency: `req` high in IDLE at cycle t → `grant` high at t+1.
- Data latency: `in_v[w]`/`in_d[w]` at cycle t → `out_v`/`out_d` at t+1. Throughput is one byte per cycle, with no bubbles inside a frame.
- A frame of L bytes driven by the source on cycles s..s+L-1:
  - `out_v` is high s+1..s+L.
  - `grant` falls at s+L+1.
  - Next `grant` appears no earlier than s+L+IFG+2.
- `out_d` holds its last value when `out_v`=0. Consumers must ignore it.
- `err_*` pulses coincide with the cycle `grant` goes low.
- Minimum frame-to-frame spacing on `out_v` (two back-to-back requesters): IFG+2 idle cycles (IFG gap plus IDLE and GRANT arbitration cycles, with a source answering grant in 0 cycles).
- Reset asserted mid-frame: `out_v` and `grant` drop immediately (asynchronous). The frame is lost and is not resumed.

## Test plan
- Single source 0, 60-byte frame 0x00..0x3B, N=4, IFG=12:
  - `grant[0]` one cycle after `req[0]`.
  - `out_d` sequence identical, delayed 1 cycle, `out_v` high for 60 cycles.
  - `busy` low 12+1 cycles after last byte.
- All four `req` held high, each source sending 10 bytes of its own index:
  - Grant order 0,1,2,3,0.
  - Exactly 12 idle `out_v` cycles after each frame (plus arbitration), no interleaving.
- Source 2 granted, `in_v[2]` never asserted, `WAIT_TIMEOUT`=16:
  - `grant[2]` low after 16 cycles, `err_timeout` pulses once, `out_v` stays 0.
  - Next requester is granted without IFG.
- Source 1 sends 2000 bytes, `MAX_LEN`=1536:
  - Exactly 1536 `out_v` cycles, then `err_trunc` pulse and `grant[1]` low.
  - Other sources' traffic is unaffected after IFG.
- Source 0 granted while source 3 toggles `in_v[3]`/`in_d[3]` = 0xFF:
  - `out_d` never shows source 3 data.
  - `req[0]` drop mid-frame does not shorten the frame.
- `rst` pulsed low during byte 20 of a frame:
  - `out_v`, `grant`, `busy` = 0 immediately.
  - After release, `req[2]` alone is granted first (`ptr`=0 scan) with correct 1-cycle latency.
